rm24_enc_ser: RTL and testbench



---
 rtl/rm24_enc_ser.sv | 65 ++++++
 tb/tb_rm24_enc_ser.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rm24_enc_ser.sv
// rm24_enc_ser: RM(2,4) encoder with one-word pending buffer and handshaked bit serializer
module rm24_enc_ser #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic [15:0]      cw_out,
  output logic [CNT_W-1:0] words_sent
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [175:0] ROWS = {16'h8888, 16'hA0A0, 16'hC0C0, 16'hAA00, 16'hCC00, 16'hF000,
                                   16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'hFFFF};
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic [15:0] code, pend_cw, pend_cw_n, cw_n;
  logic pend_full, pend_full_n, acc, hs, done, load;
  logic [CNT_W-1:0] words_n;
  always_comb begin
    code = '0;
    for (int k = 0; k < 11; k++) code = code ^ (msg_in[k] ? ROWS[16*k +: 16] : 16'h0);
  end
  assign msg_ready = !pend_full && !rst;
  assign acc = msg_valid && msg_ready;
  assign hs = state == SHIFT && ser_ready;
  assign done = hs && idx == 4'd15;
  assign load = pend_full && (state == IDLE || done);
  assign ser_valid = state == SHIFT;
  assign ser_first = ser_valid && idx == 4'd0;
  assign ser_last = ser_valid && idx == 4'd15;
  assign ser_out = ser_valid && cw_out[MSB_FIRST ? 4'd15 - idx : idx];
  always_comb begin
    state_n = load ? SHIFT : done ? IDLE : state;
    idx_n = load ? 4'd0 : hs ? idx + 4'd1 : idx;
    cw_n = load ? pend_cw : cw_out;
    pend_cw_n = acc ? code : pend_cw;
    pend_full_n = acc ? 1'b1 : load ? 1'b0 : pend_full;
    words_n = done ? words_sent + CNT_W'(1) : words_sent;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cw_out <= '0;
      pend_cw <= '0;
      pend_full <= 1'b0;
      words_sent <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cw_out <= cw_n;
      pend_cw <= pend_cw_n;
      pend_full <= pend_full_n;
      words_sent <= words_n;
    end
  end
endmodule

// File: tb/tb_rm24_enc_ser.sv
// tb_rm24_enc_ser: randomized self-checking bench for rm24_enc_ser against a polynomial-evaluation model
module tb_rm24_enc_ser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [10:0] msg_in = '0;
  logic msg_valid = 1'b0;
  logic ser_ready = 1'b1;
  logic msg_ready0, ser_out0, ser_valid0, ser_first0, ser_last0;
  logic msg_ready1, ser_out1, ser_valid1, ser_first1, ser_last1;
  logic [15:0] cw_out0, cw_out1, words_sent0;
  logic [1:0] words_sent1;
  int cmp = 0, err = 0, cyc = 0, pos = 0, nsent = 0, acc_edge = 0, acc_n = 0;
  logic feed_en = 1'b1;
  logic [10:0] tx_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] ew;
  logic [22:0] exp_vec = 'x;
  logic [22:0] dut_vec;
  logic a_s, h_s;

  rm24_enc_ser #(.MSB_FIRST(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready0),
    .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_first(ser_first0),
    .ser_last(ser_last0), .cw_out(cw_out0), .words_sent(words_sent0)
  );
  rm24_enc_ser #(.MSB_FIRST(1'b0), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready1),
    .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_first(ser_first1),
    .ser_last(ser_last1), .cw_out(cw_out1), .words_sent(words_sent1)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ser_valid1, ser_out0, ser_out1, ser_first0, ser_first1, ser_last0, ser_last1, cw_out0};

  function automatic logic [15:0] rm(input logic [10:0] m);
    logic [15:0] c;
    logic [3:0] x;
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      c[i] = m[0] ^ (m[1] & x[3]) ^ (m[2] & x[2]) ^ (m[3] & x[1]) ^ (m[4] & x[0])
           ^ (m[5] & x[3] & x[2]) ^ (m[6] & x[3] & x[1]) ^ (m[7] & x[3] & x[0])
           ^ (m[8] & x[2] & x[1]) ^ (m[9] & x[2] & x[0]) ^ (m[10] & x[1] & x[0]);
    end
    return c;
  endfunction

  always @(posedge clk) begin
    cyc++;
    a_s = msg_valid && msg_ready0;
    h_s = ser_valid0 && ser_ready;
    if (rst) begin
      exp_q.delete();
      pos = 0;
      nsent = 0;
    end else begin
      if (h_s) begin
        if (pos == 15) begin
          void'(exp_q.pop_front());
          pos = 0;
          nsent++;
        end else pos++;
      end
      if (a_s) begin
        exp_q.push_back(rm(msg_in));
        acc_edge = cyc;
        acc_n++;
      end
    end
    ew = exp_q.size() != 0 ? exp_q[0] : 16'hxxxx;
    exp_vec = exp_q.size() != 0 ? {1'b1, ew[15-pos], ew[pos], pos == 0, pos == 0, pos == 15, pos == 15, ew} : 'x;
    #1;
    if (a_s && !rst) void'(tx_q.pop_front());
    msg_valid = feed_en && tx_q.size() != 0;
    msg_in = tx_q.size() != 0 ? tx_q[0] : 11'($urandom);
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp++;
    if ({msg_ready0, msg_ready1, ser_valid0, ser_out0, ser_first0, ser_last0, cw_out0, words_sent0, words_sent1} !== '0) begin
      err++;
      $display("FAIL reset_hold: got rdy=%b%b v=%b o=%b f=%b l=%b cw=%h w=%h/%h, want all 0",
               msg_ready0, msg_ready1, ser_valid0, ser_out0, ser_first0, ser_last0, cw_out0, words_sent0, words_sent1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp++;
    if ({msg_ready0, msg_ready1, ser_valid0, ser_valid1, words_sent0} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      err++;
      $display("FAIL reset_release: got rdy=%b%b v=%b%b w=%h, want rdy=11 v=00 w=0",
               msg_ready0, msg_ready1, ser_valid0, ser_valid1, words_sent0);
    end
  endtask

  task automatic test_single;
    int fv = -1, ff = -1, lc = -1, nv = 0;
    tx_q.push_back(11'h001);
    repeat (24) begin
      @(negedge clk);
      if (ser_valid0) begin
        nv++;
        if (fv < 0) fv = cyc;
        if (ser_first0) ff = cyc;
        if (ser_last0) lc = cyc;
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL single_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
    end
    cmp++;
    if (fv != acc_edge + 1) begin err++; $display("FAIL single_latency: first valid cycle %0d, want %0d", fv, acc_edge + 1); end
    cmp++;
    if (nv != 16 || ff != fv || lc - ff != 15) begin
      err++;
      $display("FAIL single_frame: valid=%0d first@%0d last@%0d start@%0d, want 16 valid, last 15 after first", nv, ff, lc, fv);
    end
    cmp++;
    if (cw_out0 !== 16'hFFFF || words_sent0 !== 16'd1) begin
      err++;
      $display("FAIL single_cw: cw=%h words=%0d, want FFFF and 1", cw_out0, words_sent0);
    end
  endtask

  task automatic test_pattern;
    logic [15:0] b0 = '0, b1 = '0;
    int n = 0;
    tx_q.push_back(11'h012);
    repeat (24) begin
      @(negedge clk);
      if (ser_valid0) begin
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL pattern_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
        if (ser_ready) begin b0 = {b0[14:0], ser_out0}; b1 = {b1[14:0], ser_out1}; n++; end
      end
    end
    cmp++;
    if (n != 16 || b0 !== 16'h55AA || cw_out0 !== 16'h55AA) begin
      err++;
      $display("FAIL pattern_msb: bits=%0d stream=%h cw=%h, want 16 bits 55AA cw 55AA", n, b0, cw_out0);
    end
    cmp++;
    if (b1 !== 16'h55AA || cw_out1 !== 16'h55AA) begin
      err++;
      $display("FAIL pattern_lsb: stream=%h cw=%h, want 55AA 55AA", b1, cw_out1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b = '0;
    int fv = -1, lv = -1, nv = 0, f1 = -1, f2 = -1, w0;
    w0 = int'(words_sent0);
    tx_q.push_back(11'h002);
    tx_q.push_back(11'h400);
    repeat (44) begin
      @(negedge clk);
      if (ser_valid0) begin
        nv++;
        if (fv < 0) fv = cyc;
        lv = cyc;
        if (ser_first0) begin if (f1 < 0) f1 = cyc; else f2 = cyc; end
        b = {b[30:0], ser_out0};
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL b2b_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
    end
    cmp++;
    if (nv != 32 || lv - fv != 31) begin err++; $display("FAIL b2b_contiguous: valid=%0d span=%0d, want 32 and 31", nv, lv - fv); end
    cmp++;
    if (f1 != fv || f2 - f1 != 16) begin err++; $display("FAIL b2b_first: first@%0d,%0d start@%0d, want offsets 0 and 16", f1, f2, fv); end
    cmp++;
    if (b !== 32'hFF008888 || int'(words_sent0) != w0 + 2) begin
      err++;
      $display("FAIL b2b_bits: stream=%h words=%0d, want FF008888 and %0d", b, words_sent0, w0 + 2);
    end
  endtask

  task automatic test_stall;
    int idx = 0, st = 0, fv = -1, lc = -1, base;
    logic sf = 1'b0;
    logic [23:0] snap = '0;
    base = acc_n;
    tx_q.push_back(11'h7FF);
    tx_q.push_back(11'($urandom));
    tx_q.push_back(11'($urandom));
    repeat (72) begin
      @(negedge clk);
      if (ser_valid0) begin
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL stall_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
      if (st > 0) begin
        cmp++;
        if ({dut_vec, ser_valid0} !== snap) begin err++; $display("FAIL stall_freeze t=%0d: got %h want %h", cyc, {dut_vec, ser_valid0}, snap); end
        st--;
        ser_ready = st == 0;
      end else if (ser_valid0 && lc < 0 && idx == 5 && !sf) begin
        snap = {dut_vec, ser_valid0};
        st = 3;
        sf = 1'b1;
        ser_ready = 1'b0;
      end
      if (ser_valid0 && fv < 0) fv = cyc;
      if (lc >= 0 && cyc == lc + 1) begin
        cmp++;
        if (msg_ready0 !== 1'b1) begin err++; $display("FAIL stall_reload_ready: got %b want 1", msg_ready0); end
      end
      if (ser_valid0 && ser_ready && lc < 0) begin
        if (idx == 15) begin
          lc = cyc;
          cmp++;
          if (acc_n - base != 2 || msg_ready0 !== 1'b0) begin
            err++;
            $display("FAIL stall_holdoff: accepted=%0d ready=%b, want 2 and 0", acc_n - base, msg_ready0);
          end
        end
        idx++;
      end
    end
    ser_ready = 1'b1;
    cmp++;
    if (lc - fv + 1 != 19) begin err++; $display("FAIL stall_length: frame %0d cycles, want 19", lc - fv + 1); end
  endtask

  task automatic test_mid_reset;
    int idx = 0;
    logic hit = 1'b0;
    repeat (3) tx_q.push_back(11'($urandom));
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (ser_valid0) begin
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL midrst_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
      if (ser_valid0 && idx == 8 && !msg_ready0) begin
        hit = 1'b1;
        rst = 1'b1;
      end else if (ser_valid0 && ser_ready) idx++;
    end
    cmp++;
    if (!hit) begin err++; $display("FAIL midrst_reach: index 8 with pending word not reached, got idx=%0d", idx); end
    if (hit) begin
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      cmp++;
      if ({ser_valid0, msg_ready0, words_sent0, words_sent1} !== {1'b0, 1'b1, 16'h0, 2'h0}) begin
        err++;
        $display("FAIL midrst_state: v=%b rdy=%b words=%0d/%0d, want 0 1 0 0", ser_valid0, msg_ready0, words_sent0, words_sent1);
      end
    end
    repeat (40) begin
      @(negedge clk);
      if (ser_valid0) begin
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL midrst_fresh t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
    end
    cmp++;
    if (words_sent0 !== 16'd1) begin err++; $display("FAIL midrst_count: words=%0d want 1", words_sent0); end
  endtask

  task automatic test_wrap;
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int i = 0;
    logic pl = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tx_q.push_back(11'($urandom));
    repeat (120) begin
      @(negedge clk);
      if (ser_valid0) begin
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL wrap_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
      if (pl && i < 5) begin
        cmp++;
        if (words_sent1 !== seq[i]) begin err++; $display("FAIL wrap_count%0d: got %0d want %0d", i, words_sent1, seq[i]); end
        i++;
      end
      pl = ser_valid0 && ser_last0 && ser_ready;
    end
    cmp++;
    if (i != 5 || words_sent0 !== 16'd5) begin err++; $display("FAIL wrap_frames: frames=%0d words=%0d, want 5 5", i, words_sent0); end
  endtask

  task automatic test_random;
    repeat (20) tx_q.push_back(11'($urandom));
    repeat (500) begin
      @(negedge clk);
      if (ser_valid0) begin
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL rand_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
      cmp++;
      if ({words_sent0, words_sent1} !== {16'(nsent), 2'(nsent)}) begin
        err++;
        $display("FAIL rand_words t=%0d: got %0d/%0d want %0d", cyc, words_sent0, words_sent1, nsent);
      end
      feed_en = $urandom_range(0, 3) != 0;
      ser_ready = $urandom_range(0, 3) != 0;
    end
    feed_en = 1'b1;
    ser_ready = 1'b1;
    for (int c = 0; c < 500 && (tx_q.size() != 0 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (ser_valid0) begin
        cmp++;
        if (dut_vec !== exp_vec) begin err++; $display("FAIL drain_stream t=%0d: got %h want %h", cyc, dut_vec, exp_vec); end
      end
    end
    cmp++;
    if (tx_q.size() != 0 || exp_q.size() != 0 || words_sent0 !== 16'(nsent)) begin
      err++;
      $display("FAIL drain_done: queued=%0d inflight=%0d words=%0d, want 0 0 %0d", tx_q.size(), exp_q.size(), words_sent0, nsent);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_pattern;
    test_back_to_back;
    test_stall;
    test_mid_reset;
    test_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", cmp);
    $fatal(1, "timeout");
  end
endmodule
